// File: rtl/ex_muldiv_seq.sv
// Multi-cycle multiply/divide engine: MUL_STEP-bit shift-add multiply, restoring radix-2 divide.
// Optional MULDIV_EARLY_OUT_EN: MUL leaves early once the remaining multiplier bits are zero.
module ex_muldiv_seq #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int N_MUL = WIDTH / MUL_STEP;
  localparam int CW    = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;   // MUL: product; DIV: {remainder, quotient}
  logic [2*WIDTH-1:0] opa_q, opa_d;   // MUL: shifted multiplicand; DIV: divisor in low half
  logic [WIDTH-1:0]   opb_q, opb_d;   // MUL: unretired multiplier bits
  logic               is_div_q, is_div_d;
  logic               zdiv_q, zdiv_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dbz_q, dbz_d;

  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] pp, prod_fix;
  logic [WIDTH:0]     div_ext, div_diff;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign sa    = a[WIDTH-1] & ~op[0];
  assign sb    = b[WIDTH-1] & ~op[0];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  assign pp       = opa_q * (2*WIDTH)'(opb_q[MUL_STEP-1:0]);
  assign div_ext  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_ext - {1'b0, opa_q[WIDTH-1:0]};
  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    zdiv_d   = zdiv_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          is_div_d = op[1];
          dbz_d    = 1'b0;
          zdiv_d   = 1'b0;
          neg_lo_d = sa ^ sb;
          neg_hi_d = op[1] ? sa : (sa ^ sb);
          if (op[1]) begin
            if (b == '0) begin
              // Divide by zero skips iteration; hi must return a untouched.
              zdiv_d  = 1'b1;
              acc_d   = {{WIDTH{1'b0}}, a};
              state_d = S_FIX;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, mag_a};
              opa_d   = {{WIDTH{1'b0}}, mag_b};
              cnt_d   = CW'(WIDTH - 1);
              state_d = S_DIV;
            end
          end else begin
            acc_d   = '0;
            opa_d   = {{WIDTH{1'b0}}, mag_a};
            opb_d   = mag_b;
            cnt_d   = CW'(N_MUL - 1);
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_q + pp;
        opa_d = opa_q << MUL_STEP;
        opb_d = opb_q >> MUL_STEP;
        cnt_d = cnt_q - CW'(1);
`ifdef MULDIV_EARLY_OUT_EN
        if (cnt_q == '0 || opb_d == '0) state_d = S_FIX;
`else
        if (cnt_q == '0) state_d = S_FIX;
`endif
      end
      S_DIV: begin
        // Restoring step: keep the trial difference only when it did not borrow.
        if (div_diff[WIDTH])
          acc_d = {div_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
          acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (zdiv_q) begin
          lo_d  = '1;
          hi_d  = acc_q[WIDTH-1:0];
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      zdiv_q   <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      zdiv_q   <= zdiv_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq (WIDTH=32, MUL_STEP=4) with hand-computed results.
module tb_ex_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, dbz;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           lat, bcnt, dcnt;
  logic [W-1:0] lo_seen;

  always #5 clk = ~clk;

  ex_muldiv_seq #(.WIDTH(W), .MUL_STEP(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dbz)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is high.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int l, output int bc);
    bit got;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    l = 1; bc = 0; got = 0;
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~x; b = ~y;
    while (!got && l < 100) begin
      if (done) got = 1;
      else begin
        if (busy) bc++;
        @(negedge clk);
        l++;
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    $display("[TB] op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0d edges=%0d",
             o, x, y, hi, lo, dbz, l);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
    chk("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
    chk("multu_max_lo", 64'(lo), 64'h00000001);
`ifndef MULDIV_EARLY_OUT_EN
    chk("mul_latency", 64'(lat), 64'd10);
    chk("mul_busy_edges", 64'(bcnt), 64'd9);
`endif

    run_op(2'b00, 32'hFFFFFFF9, 32'd3, lat, bcnt);
    chk("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_neg_lo", 64'(lo), 64'hFFFFFFEB);

    // Issued in the done cycle of the previous op.
    run_op(2'b11, 32'd100, 32'd7, lat, bcnt);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);
`ifndef MULDIV_EARLY_OUT_EN
    chk("div_latency", 64'(lat), 64'd34);
`endif

    run_op(2'b00, 32'h80000000, 32'h80000000, lat, bcnt);
    chk("mult_min_hi", 64'(hi), 64'h40000000);
    chk("mult_min_lo", 64'(lo), 64'h0);

    run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, bcnt);
    chk("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_neg_hi", 64'(hi), 64'hFFFFFFFF);

    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
    chk("div_ovf_lo", 64'(lo), 64'h80000000);
    chk("div_ovf_hi", 64'(hi), 64'h0);

    run_op(2'b10, 32'd7, 32'hFFFFFFFE, lat, bcnt);
    chk("div_negb_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_negb_hi", 64'(hi), 64'd1);

    // Flush on the 10th DIV cycle.
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    dcnt = 0;
    repeat (40) begin @(negedge clk); if (done) dcnt++; end
    chk("flush_no_done", 64'(dcnt), 64'd0);
    chk("flush_hi_kept", 64'(hi), 64'd1);
    chk("flush_lo_kept", 64'(lo), 64'hFFFFFFFD);
    $display("[TB] flush in DIV: busy=%0d dones=%0d hi=0x%08h lo=0x%08h", busy, dcnt, hi, lo);

    // start and flush together: start is dropped.
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("startflush_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("startflush_busy2", 64'(busy), 64'd0);
    chk("startflush_done", 64'(done), 64'd0);
    $display("[TB] start+flush: busy=%0d done=%0d", busy, done);

    // Flush during FIX of a divide-by-zero discards the result.
    start = 1'b1; op = 2'b11; a = 32'd5; b = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    dcnt = 0;
    repeat (4) begin if (done) dcnt++; @(negedge clk); end
    chk("fixflush_no_done", 64'(dcnt), 64'd0);
    chk("fixflush_lo_kept", 64'(lo), 64'hFFFFFFFD);
    chk("fixflush_dbz", 64'(dbz), 64'd0);
    $display("[TB] flush in FIX: dones=%0d lo=0x%08h dbz=%0d", dcnt, lo, dbz);

    run_op(2'b11, 32'd5, 32'd0, lat, bcnt);
    chk("dbz_lo", 64'(lo), 64'hFFFFFFFF);
    chk("dbz_hi", 64'(hi), 64'd5);
    chk("dbz_flag", 64'(dbz), 64'd1);
    chk("dbz_latency", 64'(lat), 64'd2);

    run_op(2'b01, 32'd2, 32'd3, lat, bcnt);
    chk("after_dbz_flag", 64'(dbz), 64'd0);
    chk("after_dbz_lo", 64'(lo), 64'd6);

    run_op(2'b10, 32'hFFFFFFF9, 32'd0, lat, bcnt);
    chk("sdbz_hi", 64'(hi), 64'hFFFFFFF9);
    chk("sdbz_flag", 64'(dbz), 64'd1);

    // A start while busy is ignored.
    start = 1'b1; op = 2'b01; a = 32'd4; b = 32'd5;
    @(negedge clk);
    a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0; lo_seen = '0;
    repeat (30) begin
      if (done) begin dcnt++; lo_seen = lo; end
      @(negedge clk);
    end
    chk("busy_start_dones", 64'(dcnt), 64'd1);
    chk("busy_start_lo", 64'(lo_seen), 64'd20);
    $display("[TB] start while busy: dones=%0d lo=0x%08h", dcnt, lo_seen);

    // Asynchronous reset mid-MUL.
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    $display("[TB] async reset mid-MUL: busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'b01, 32'd2, 32'd3, lat, bcnt);
    chk("post_rst_lo", 64'(lo), 64'd6);
    chk("post_rst_hi", 64'(hi), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
